lif_tdm_scheduler: RTL and testbench
====================================

// Module: lif_tdm_scheduler
// PURPOSE
//  Time-multiplexes one LIF update datapath across N_NEURONS virtual neurons (leg CPG bank).
//  Each accepted tick, scans neurons 0..N-1 one per cycle: read state, leak/integrate/fire, write back.
//  Holds per-neuron i_ext/thresh config, membrane voltage and refractory count in internal register files.
//  Sits between the gait-timing tick generator and the spike consumers (motor pattern logic).
// PARAMETERS
//  N_NEURONS   4  number of virtual neurons (2..16)
//  WIDTH       8  voltage / i_ext / thresh width
//  LEAK_SHIFT  3  leak = v >> LEAK_SHIFT per tick
//  REFRAC      2  refractory ticks after a spike (0 = none)
// PORTS
//  clk          in   1               system clock, all state on posedge
//  reset        in   1               asynchronous, active-low; clears all state
//  tick         in   1               start one scan; sampled only in IDLE
//  cfg_we       in   1               config write strobe
//  cfg_addr     in   $clog2(N)       neuron index for config write
//  cfg_iext     in   WIDTH           input current for cfg_addr
//  cfg_thresh   in   WIDTH           firing threshold for cfg_addr (0 = neuron disabled)
//  busy         out  1               high during SCAN and DONE
//  done         out  1               1-cycle pulse at end of scan
//  overrun      out  1               1-cycle pulse: tick seen while busy (tick dropped)
//  spike_valid  out  1               1-cycle pulse in SCAN cycle where a neuron fires
//  spike_id     out  $clog2(N)       index of firing neuron, valid with spike_valid
//  spike_vec    out  N_NEURONS       spikes of last completed scan, bit i = neuron i
// BEHAVIOUR
//  Reset: all outputs 0; all voltages, refractory counts, i_ext, thresh = 0; state IDLE.
//  FSM: IDLE --tick--> SCAN (idx=0); SCAN idx++ each cycle, idx==N-1 -> DONE; DONE -> IDLE.
//  Latency: tick at edge k -> busy from k+1, SCAN k+1..k+N, done high in cycle k+N+1; next tick accepted k+N+2.
//  Per neuron (SCAN cycle idx), unsigned, computed in WIDTH+1 bits:
//   leak = v >> LEAK_SHIFT; in = (refrac>0) ? 0 : i_ext;
//   v_n = v - leak + in, saturate to 2^WIDTH-1.
//   thresh==0: v <= 0, refrac <= 0, no spike.
//   else if refrac==0 and v_n >= thresh: spike; v <= 0; refrac <= REFRAC.
//   else v <= v_n; refrac <= refrac - (refrac!=0).
//  spike_valid/spike_id registered: asserted cycle after the neuron's SCAN cycle (last at DONE).
//  spike_vec accumulates privately during scan; copied to output at DONE edge; held until next DONE.
//  cfg write: accepted in any state; cfg_addr >= N ignored. Write to neuron being scanned same
//   cycle -> scan uses old values; new values apply from next tick. Voltage untouched by cfg.
//  tick while busy: dropped, overrun pulses next cycle; scan in progress unaffected.
//  tick and cfg_we same cycle in IDLE: write lands first; neuron 0 write visible only if idx scan
//   reads after edge (it does: SCAN starts next cycle) -> new value used.
//  Reset mid-scan: immediate abort to IDLE, all state cleared, no done.
// CONFIGURATION
//  LIF_VOLT_TAP_EN defined: adds outputs volt_valid(1), volt_id($clog2(N)), volt_data(WIDTH),
//   registered like spike_valid, one beat per neuron per scan carrying written-back v (0 on spike).
//   Reset value 0.
//  Not defined: ports absent, no voltage observability beyond spikes; core behaviour identical.
// TESTING (N=4, WIDTH=8, LEAK_SHIFT=3, REFRAC=2)
//  Reset held, tick pulsed -> busy, done, spike_vec stay 0; release -> idle, no activity.
//  n0 iext=10 thr=20, others thr=0, tick every 8 cycles -> v 10,19 then spike on tick 3
//   (spike_id=0, spike_vec=4'b0001 after done); refractory ticks 4,5 v=0; next spike tick 8 (period 5).
//  n2 iext=255 thr=255 -> spike every tick when REFRAC ticks elapsed (ticks 1,4,7); v saturates, no wrap.
//  tick at k -> done exactly at k+5; second tick at k+2 -> overrun pulse at k+3, only one done.
//  cfg write n0 thr=0 during n0's SCAN cycle -> that scan fires per old cfg; next scan v=0, no spike.
//  reset asserted mid-SCAN (idx=2) -> busy=0 immediately, no done, all voltages 0 on next tick.

Source files
------------

// File: rtl/lif_tdm_scheduler_if.sv
// Tick/config/spike bundle between the gait tick source, the config master and the LIF scheduler.
// The voltage tap signals exist only when LIF_VOLT_TAP_EN is defined.
interface lif_tdm_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8
);
  localparam int IW = $clog2(N_NEURONS);

  logic                 tick;
  logic                 cfg_we;
  logic [IW-1:0]        cfg_addr;
  logic [WIDTH-1:0]     cfg_iext;
  logic [WIDTH-1:0]     cfg_thresh;
  logic                 busy;
  logic                 done;
  logic                 overrun;
  logic                 spike_valid;
  logic [IW-1:0]        spike_id;
  logic [N_NEURONS-1:0] spike_vec;
`ifdef LIF_VOLT_TAP_EN
  logic                 volt_valid;
  logic [IW-1:0]        volt_id;
  logic [WIDTH-1:0]     volt_data;
`endif

  modport master (
    output tick, cfg_we, cfg_addr, cfg_iext, cfg_thresh,
`ifdef LIF_VOLT_TAP_EN
    input  volt_valid, volt_id, volt_data,
`endif
    input  busy, done, overrun, spike_valid, spike_id, spike_vec
  );

  modport slave (
    input  tick, cfg_we, cfg_addr, cfg_iext, cfg_thresh,
`ifdef LIF_VOLT_TAP_EN
    output volt_valid, volt_id, volt_data,
`endif
    output busy, done, overrun, spike_valid, spike_id, spike_vec
  );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed LIF neuron bank (one shared datapath); optional voltage tap under LIF_VOLT_TAP_EN.
// Latency: tick -> N_NEURONS SCAN cycles + 1 DONE cycle; spike/volt beats trail their scan cycle by one.
// Backpressure: none; a tick arriving while busy is dropped and flagged by a one-cycle overrun pulse.
module lif_tdm_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2
) (
  input logic            clk,
  input logic            reset,
  lif_tdm_scheduler_if.slave bus
);
  localparam int IW = $clog2(N_NEURONS);
  localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state;
  state_t               state_nx;
  logic [IW-1:0]        idx;
  logic                 last_idx;
  logic                 scan_en;
  logic                 in_idle;

  logic [WIDTH-1:0]     v_mem    [N_NEURONS];
  logic [RW-1:0]        ref_mem  [N_NEURONS];
  logic [WIDTH-1:0]     iext_mem [N_NEURONS];
  logic [WIDTH-1:0]     thr_mem  [N_NEURONS];

  logic [WIDTH-1:0]     v_cur;
  logic [RW-1:0]        ref_cur;
  logic [WIDTH-1:0]     iext_cur;
  logic [WIDTH-1:0]     thr_cur;
  logic [WIDTH-1:0]     leak;
  logic [WIDTH-1:0]     inp;
  logic [WIDTH:0]       v_sum;
  logic [WIDTH-1:0]     v_sat;
  logic [WIDTH-1:0]     v_wb;
  logic [RW-1:0]        ref_wb;
  logic                 fire;
  logic [N_NEURONS-1:0] fire_vec;
  logic [N_NEURONS-1:0] acc;
  logic [N_NEURONS-1:0] acc_nx;

  assign last_idx = (idx == IW'(N_NEURONS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (state == SCAN) idx <= idx + IW'(1);
      else               idx <= '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.tick) state_nx = SCAN;
      SCAN:    if (last_idx) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_idle  = (state == IDLE);
    scan_en  = (state == SCAN);
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // Shared update datapath; a cfg write in this same cycle lands only at the edge, so the old values are used.
  always_comb begin
    v_cur    = v_mem[idx];
    ref_cur  = ref_mem[idx];
    iext_cur = iext_mem[idx];
    thr_cur  = thr_mem[idx];
    leak     = v_cur >> LEAK_SHIFT;
    inp      = (ref_cur != '0) ? '0 : iext_cur;
    v_sum    = {1'b0, v_cur} - {1'b0, leak} + {1'b0, inp};
    v_sat    = v_sum[WIDTH] ? '1 : v_sum[WIDTH-1:0];
    fire     = (thr_cur != '0) && (ref_cur == '0) && (v_sat >= thr_cur);
    if (thr_cur == '0) begin
      v_wb   = '0;
      ref_wb = '0;
    end else if (fire) begin
      v_wb   = '0;
      ref_wb = RW'(REFRAC);
    end else begin
      v_wb   = v_sat;
      ref_wb = (ref_cur == '0) ? '0 : ref_cur - RW'(1);
    end
    fire_vec      = '0;
    fire_vec[idx] = fire;
    acc_nx        = acc | fire_vec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i]   <= '0;
        ref_mem[i] <= '0;
      end
    end else if (scan_en) begin
      v_mem[idx]   <= v_wb;
      ref_mem[idx] <= ref_wb;
    end
  end

  // Addresses at or above N_NEURONS match no entry and are silently dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        iext_mem[i] <= '0;
        thr_mem[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (bus.cfg_we && (bus.cfg_addr == IW'(i))) begin
          iext_mem[i] <= bus.cfg_iext;
          thr_mem[i]  <= bus.cfg_thresh;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc             <= '0;
      bus.spike_vec   <= '0;
      bus.spike_valid <= 1'b0;
      bus.spike_id    <= '0;
      bus.overrun     <= 1'b0;
    end else begin
      bus.overrun     <= bus.tick && !in_idle;
      bus.spike_valid <= scan_en && fire;
      if (scan_en) bus.spike_id <= idx;
      if (scan_en)      acc <= acc_nx;
      else if (in_idle) acc <= '0;
      // Published as the scan finishes, so it already includes the last neuron.
      if (scan_en && last_idx) bus.spike_vec <= acc_nx;
    end
  end

`ifdef LIF_VOLT_TAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.volt_valid <= 1'b0;
      bus.volt_id    <= '0;
      bus.volt_data  <= '0;
    end else begin
      bus.volt_valid <= scan_en;
      if (scan_en) begin
        bus.volt_id   <= idx;
        bus.volt_data <= v_wb;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Bench for lif_tdm_scheduler: directed gait scenarios plus randomized cfg/tick traffic vs a per-tick LIF model.
module tb_lif_tdm_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lif_tdm_scheduler_if #(.N_NEURONS(N), .WIDTH(W)) bus ();

  lif_tdm_scheduler #(.N_NEURONS(N), .WIDTH(W), .LEAK_SHIFT(3), .REFRAC(2)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int m_v [N];
  int m_ref [N];
  int m_iext [N];
  int m_thr [N];
  logic [N-1:0] m_vec;

  task automatic model_reset();
    for (int n = 0; n < N; n++) begin
      m_v[n] = 0; m_ref[n] = 0; m_iext[n] = 0; m_thr[n] = 0;
    end
    m_vec = '0;
  endtask

  task automatic model_cfg(input int a, input int i, input int t);
    m_iext[a] = i;
    m_thr[a]  = t;
  endtask

  // One tick of the whole bank. A write issued in scan-relative cycle wcyc is visible to neuron n only if n >= wcyc.
  task automatic model_tick(input int wcyc, input int wa, input int wi, input int wt);
    m_vec = '0;
    for (int n = 0; n < N; n++) begin
      int inp;
      int vn;
      if (wcyc >= 0 && n == wa && n >= wcyc) model_cfg(wa, wi, wt);
      inp = (m_ref[n] > 0) ? 0 : m_iext[n];
      vn  = m_v[n] - m_v[n] / 8 + inp;
      if (vn > 255) vn = 255;
      if (m_thr[n] == 0) begin
        m_v[n] = 0; m_ref[n] = 0;
      end else if (m_ref[n] == 0 && vn >= m_thr[n]) begin
        m_vec[n] = 1'b1; m_v[n] = 0; m_ref[n] = 2;
      end else begin
        m_v[n] = vn;
        if (m_ref[n] > 0) m_ref[n] = m_ref[n] - 1;
      end
    end
    if (wcyc >= 0) model_cfg(wa, wi, wt);
  endtask

  task automatic cfg_write(input int a, input int i, input int t);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = a[1:0]; bus.cfg_iext = i[7:0]; bus.cfg_thresh = t[7:0];
    @(negedge clk);
    bus.cfg_we = 1'b0;
    model_cfg(a, i, t);
  endtask

  // Drives one tick (scan cycle 0) and observes cycles 1..7; xt = extra tick cycle, wcyc = cfg write cycle (-1 = none).
  task automatic run_scan(input int xt, input int wcyc, input int wa, input int wi, input int wt,
                          output logic [N-1:0] pulses, output logic id_bad, output logic busy_bad,
                          output int done_cyc, output int done_cnt, output int ovr_cyc, output int ovr_cnt,
                          output logic [N-1:0] vec);
    pulses = '0; id_bad = 1'b0; busy_bad = 1'b0;
    done_cyc = -1; done_cnt = 0; ovr_cyc = -1; ovr_cnt = 0;
    @(negedge clk);
    bus.tick = 1'b1;
    if (wcyc == 0) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = wa[1:0]; bus.cfg_iext = wi[7:0]; bus.cfg_thresh = wt[7:0];
    end
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      bus.tick = 1'b0; bus.cfg_we = 1'b0;
      if (bus.spike_valid) begin
        pulses[bus.spike_id] = 1'b1;
        if (j < 2 || j > 5 || int'(bus.spike_id) != j - 2) id_bad = 1'b1;
      end
      if (bus.busy !== (j <= 5)) busy_bad = 1'b1;
      if (bus.done) begin done_cnt++; done_cyc = j; end
      if (bus.overrun) begin ovr_cnt++; ovr_cyc = j; end
      if (j == xt) bus.tick = 1'b1;
      if (j == wcyc) begin
        bus.cfg_we = 1'b1; bus.cfg_addr = wa[1:0]; bus.cfg_iext = wi[7:0]; bus.cfg_thresh = wt[7:0];
      end
    end
    vec = bus.spike_vec;
  endtask

  logic [N-1:0] pulses, vec;
  logic id_bad, busy_bad;
  int done_cyc, done_cnt, ovr_cyc, ovr_cnt;

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.overrun, bus.spike_valid, bus.spike_vec} !== '0) begin
        errors++;
        $display("FAIL reset_hold: busy=%b done=%b ovr=%b sv=%b vec=%b required all 0",
                 bus.busy, bus.done, bus.overrun, bus.spike_valid, bus.spike_vec);
      end
    end
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.overrun, bus.spike_valid, bus.spike_vec} !== '0) begin
        errors++;
        $display("FAIL reset_release_idle: busy=%b done=%b vec=%b required 0", bus.busy, bus.done, bus.spike_vec);
      end
    end
  endtask

  task automatic test_periodic_n0();
    cfg_write(0, 10, 20);
    for (int t = 1; t <= 8; t++) begin
      run_scan(-1, -1, 0, 0, 0, pulses, id_bad, busy_bad, done_cyc, done_cnt, ovr_cyc, ovr_cnt, vec);
      model_tick(-1, 0, 0, 0);
      checks++;
      if (vec[0] !== (t == 3 || t == 8)) begin
        errors++; $display("FAIL periodic_n0 tick %0d: spike_vec[0]=%b required %b", t, vec[0], (t == 3 || t == 8));
      end
      checks++;
      if (vec !== m_vec || pulses !== m_vec || id_bad) begin
        errors++; $display("FAIL periodic_vec tick %0d: vec=%b pulses=%b id_bad=%b required %b", t, vec, pulses, id_bad, m_vec);
      end
      checks++;
      if (done_cyc != 5 || done_cnt != 1 || busy_bad) begin
        errors++; $display("FAIL periodic_timing tick %0d: done_cyc=%0d cnt=%0d busy_bad=%b required 5/1/0", t, done_cyc, done_cnt, busy_bad);
      end
    end
  endtask

  task automatic test_saturate_n2();
    cfg_write(2, 255, 255);
    for (int t = 1; t <= 7; t++) begin
      run_scan(-1, -1, 0, 0, 0, pulses, id_bad, busy_bad, done_cyc, done_cnt, ovr_cyc, ovr_cnt, vec);
      model_tick(-1, 0, 0, 0);
      checks++;
      if (vec[2] !== (t % 3 == 1)) begin
        errors++; $display("FAIL saturate_n2 tick %0d: spike_vec[2]=%b required %b", t, vec[2], (t % 3 == 1));
      end
      checks++;
      if (vec !== m_vec || pulses !== m_vec || id_bad) begin
        errors++; $display("FAIL saturate_vec tick %0d: vec=%b pulses=%b required %b", t, vec, pulses, m_vec);
      end
    end
  endtask

  task automatic test_overrun();
    run_scan(2, -1, 0, 0, 0, pulses, id_bad, busy_bad, done_cyc, done_cnt, ovr_cyc, ovr_cnt, vec);
    model_tick(-1, 0, 0, 0);
    checks++;
    if (ovr_cyc != 3 || ovr_cnt != 1) begin
      errors++; $display("FAIL overrun_pulse: cycle=%0d count=%0d required 3/1", ovr_cyc, ovr_cnt);
    end
    checks++;
    if (done_cyc != 5 || done_cnt != 1 || busy_bad) begin
      errors++; $display("FAIL overrun_single_done: done_cyc=%0d cnt=%0d busy_bad=%b required 5/1/0", done_cyc, done_cnt, busy_bad);
    end
    checks++;
    if (vec !== m_vec || pulses !== m_vec) begin
      errors++; $display("FAIL overrun_vec: vec=%b pulses=%b required %b", vec, pulses, m_vec);
    end
  endtask

  task automatic test_cfg_during_scan();
    cfg_write(0, 200, 100);
    for (int k = 0; k < 4 && m_ref[0] != 0; k++) begin
      run_scan(-1, -1, 0, 0, 0, pulses, id_bad, busy_bad, done_cyc, done_cnt, ovr_cyc, ovr_cnt, vec);
      model_tick(-1, 0, 0, 0);
      checks++;
      if (vec !== m_vec) begin
        errors++; $display("FAIL cfg_prep_vec: vec=%b required %b", vec, m_vec);
      end
    end
    run_scan(-1, 1, 0, 200, 0, pulses, id_bad, busy_bad, done_cyc, done_cnt, ovr_cyc, ovr_cnt, vec);
    model_tick(1, 0, 200, 0);
    checks++;
    if (vec[0] !== 1'b1 || vec !== m_vec) begin
      errors++; $display("FAIL cfg_same_cycle_old: vec=%b required bit0=1 and %b", vec, m_vec);
    end
    run_scan(-1, -1, 0, 0, 0, pulses, id_bad, busy_bad, done_cyc, done_cnt, ovr_cyc, ovr_cnt, vec);
    model_tick(-1, 0, 0, 0);
    checks++;
    if (vec[0] !== 1'b0 || vec !== m_vec || pulses !== m_vec) begin
      errors++; $display("FAIL cfg_new_disabled: vec=%b pulses=%b required bit0=0 and %b", vec, pulses, m_vec);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 30; s++) begin
      int xt, wcyc, wa, wi, wt, exp_ovr;
      xt   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : -1;
      wcyc = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 6)) : -1;
      wa   = $urandom_range(0, N - 1);
      wi   = $urandom_range(0, 255);
      wt   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      run_scan(xt, wcyc, wa, wi, wt, pulses, id_bad, busy_bad, done_cyc, done_cnt, ovr_cyc, ovr_cnt, vec);
      model_tick(wcyc, wa, wi, wt);
      exp_ovr = (xt > 0) ? xt + 1 : -1;
      checks++;
      if (vec !== m_vec || pulses !== m_vec || id_bad) begin
        errors++; $display("FAIL random_spikes scan %0d: vec=%b pulses=%b id_bad=%b required %b", s, vec, pulses, id_bad, m_vec);
      end
      checks++;
      if (done_cyc != 5 || done_cnt != 1 || busy_bad || ovr_cyc != exp_ovr || ovr_cnt != (xt > 0 ? 1 : 0)) begin
        errors++; $display("FAIL random_timing scan %0d: done=%0d/%0d busy_bad=%b ovr=%0d/%0d required 5/1/0 ovr %0d",
                           s, done_cyc, done_cnt, busy_bad, ovr_cyc, ovr_cnt, exp_ovr);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    bus.tick = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus.tick = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.spike_vec !== '0) begin
      errors++; $display("FAIL reset_mid_scan_busy: busy=%b vec=%b required 0", bus.busy, bus.spike_vec);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.spike_valid !== 1'b0) begin
        errors++; $display("FAIL reset_mid_scan_nodone: done=%b busy=%b sv=%b required 0", bus.done, bus.busy, bus.spike_valid);
      end
    end
    rst_n = 1'b1;
    model_reset();
    cfg_write(1, 10, 20);
    for (int t = 1; t <= 3; t++) begin
      run_scan(-1, -1, 0, 0, 0, pulses, id_bad, busy_bad, done_cyc, done_cnt, ovr_cyc, ovr_cnt, vec);
      model_tick(-1, 0, 0, 0);
      checks++;
      if (vec !== (t == 3 ? 4'b0010 : 4'b0000) || vec !== m_vec || done_cnt != 1) begin
        errors++; $display("FAIL reset_mid_scan_cleared tick %0d: vec=%b done_cnt=%0d required %b", t, vec, done_cnt, m_vec);
      end
    end
  endtask

  initial begin
    bus.tick = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_iext = '0; bus.cfg_thresh = '0;
    test_reset();
    test_periodic_n0();
    test_saturate_n2();
    test_overrun();
    test_cfg_during_scan();
    test_random();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required run to complete");
    $fatal(1, "watchdog");
  end
endmodule
